// File: rtl/inc16_pkg.sv
// inc16_pkg: shared width, all-ones constant and word type for the incrementer
package inc16_pkg;
  localparam int INC16_W = 16;
  localparam logic [INC16_W-1:0] INC16_ONES = '1;
  typedef logic [INC16_W-1:0] word_t;
endpackage

// File: rtl/inc16_ha_cell.sv
// inc16_ha_cell: single-bit half adder, one link of the increment ripple chain
module inc16_ha_cell (
  input  logic a,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum = a ^ cin;
  assign cout = a & cin;
endmodule

// File: rtl/inc16_reg.sv
// inc16_reg: registered a+1 over a half-adder ripple chain; INC16_OVF_STICKY_EN adds ovf_sticky/ovf_clr
module inc16_reg
  import inc16_pkg::*;
#(
  parameter int WIDTH = INC16_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
`ifdef INC16_OVF_STICKY_EN
  input  logic             ovf_clr,
  output logic             ovf_sticky,
`endif
  output logic             carry
);
  logic [WIDTH:0] c;
  logic [WIDTH-1:0] sum;
  assign c[0] = 1'b1;
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    inc16_ha_cell u_cell (.a(a[i]), .cin(c[i]), .sum(sum[i]), .cout(c[i+1]));
  end
  // capture result on valid, hold it otherwise; valid is a one-cycle pulse per input
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out <= '0;
      out_valid <= 1'b0;
      carry <= 1'b0;
`ifdef INC16_OVF_STICKY_EN
      ovf_sticky <= 1'b0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out <= sum;
        carry <= c[WIDTH];
      end
`ifdef INC16_OVF_STICKY_EN
      ovf_sticky <= (in_valid & c[WIDTH]) | (ovf_sticky & ~ovf_clr);
`endif
    end
  end
endmodule

// File: tb/tb_inc16_reg.sv
// tb_inc16_reg: scoreboard bench for inc16_reg (INC16_OVF_STICKY_EN honoured if defined)
module tb_inc16_reg;
  import inc16_pkg::*;
  typedef struct {
    word_t out;
    logic  carry;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  word_t a = '0;
  word_t out;
  logic out_valid;
  logic carry;
  logic ovf_clr = 1'b0;
  logic ovf_sticky;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  inc16_reg #(.WIDTH(INC16_W)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .a(a),
    .out(out),
    .out_valid(out_valid),
`ifdef INC16_OVF_STICKY_EN
    .ovf_clr(ovf_clr),
    .ovf_sticky(ovf_sticky),
`endif
    .carry(carry)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL spurious_valid out=%h", out);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (out !== e.out || carry !== e.carry) begin
            errors++;
            $display("FAIL result got out=%h carry=%b want out=%h carry=%b", out, carry, e.out, e.carry);
          end
        end
      end else if (sb.size() != 0) begin
        checks++;
        errors++;
        $display("FAIL missing_valid want out=%h", sb[0].out);
        sb.delete();
      end
    end
  end
  task automatic drive(input logic v, input word_t x);
    exp_t e;
    @(negedge clk);
    in_valid = v;
    a = x;
    @(posedge clk);
    #1;
    if (v) begin
      e.out = x + 16'd1;
      e.carry = (x == INC16_ONES);
      sb.push_back(e);
    end
  endtask
  task automatic test_reset;
    #1;
    checks++;
    if (out !== '0 || out_valid !== 1'b0 || carry !== 1'b0) begin
      errors++;
      $display("FAIL power_on_reset got out=%h v=%b c=%b want 0000 0 0", out, out_valid, carry);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic test_basic;
    drive(1'b1, 16'h0000);
    drive(1'b1, 16'd123);
    drive(1'b0, 16'h0000);
  endtask
  task automatic test_wrap;
    drive(1'b1, INC16_ONES);
`ifdef INC16_OVF_STICKY_EN
    checks++;
    if (ovf_sticky !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set got %b want 1", ovf_sticky);
    end
    drive(1'b1, 16'd5);
    checks++;
    if (ovf_sticky !== 1'b1) begin
      errors++;
      $display("FAIL ovf_hold got %b want 1", ovf_sticky);
    end
    ovf_clr = 1'b1;
    drive(1'b1, INC16_ONES);
    checks++;
    if (ovf_sticky !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set_wins got %b want 1", ovf_sticky);
    end
    drive(1'b0, 16'h0000);
    ovf_clr = 1'b0;
    checks++;
    if (ovf_sticky !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear got %b want 0", ovf_sticky);
    end
`endif
    drive(1'b1, 16'h7FFF);
    drive(1'b0, 16'h0000);
  endtask
  task automatic test_back_to_back;
    drive(1'b1, 16'h00FF);
    drive(1'b1, 16'h7FFF);
    drive(1'b1, 16'h8000);
    for (int i = 0; i < 6; i++) drive(1'b1, word_t'($urandom));
    drive(1'b1, INC16_ONES);
    drive(1'b1, 16'hFFFE);
  endtask
  task automatic test_hold;
    drive(1'b1, 16'h1234);
    drive(1'b0, 16'hBEEF);
    checks++;
    if (out !== 16'h1235 || out_valid !== 1'b0 || carry !== 1'b0) begin
      errors++;
      $display("FAIL hold got out=%h v=%b c=%b want 1235 0 0", out, out_valid, carry);
    end
    drive(1'b0, 16'hFFFF);
    checks++;
    if (out !== 16'h1235 || carry !== 1'b0) begin
      errors++;
      $display("FAIL hold2 got out=%h c=%b want 1235 0", out, carry);
    end
  endtask
  task automatic test_async_reset;
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (out !== '0 || out_valid !== 1'b0 || carry !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got out=%h v=%b c=%b want 0000 0 0", out, out_valid, carry);
    end
`ifdef INC16_OVF_STICKY_EN
    checks++;
    if (ovf_sticky !== 1'b0) begin
      errors++;
      $display("FAIL ovf_reset got %b want 0", ovf_sticky);
    end
`endif
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic test_reset_midstream;
    drive(1'b1, INC16_ONES);
    @(negedge clk);
    in_valid = 1'b1;
    a = 16'h4444;
    #2;
    reset = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    checks++;
    if (out !== '0 || out_valid !== 1'b0 || carry !== 1'b0) begin
      errors++;
      $display("FAIL midstream_reset got out=%h v=%b c=%b want 0000 0 0", out, out_valid, carry);
    end
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out !== '0) begin
      errors++;
      $display("FAIL post_reset_idle got out=%h v=%b want 0000 0", out, out_valid);
    end
    drive(1'b1, 16'd7);
    drive(1'b0, 16'd0);
  endtask
  initial begin
    test_reset;
    test_basic;
    test_wrap;
    test_back_to_back;
    test_hold;
    test_async_reset;
    test_reset_midstream;
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #20000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule
